// File: rtl/simd_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : simd_data_mem
// Brief    : Dual-port banked data memory for the SIMD audio processor.
//            Port A : scalar byte access, sign/zero extension to 32 bits,
//                     LED/switch I/O window in the top vector row.
//            Port B : LANES-byte vector access with per-lane byte enables.
//            Storage is LANES byte-wide banks; byte address A lives in bank
//            A mod LANES, row A / LANES.
// Revision : 1.0 - initial release
// ============================================================================
module simd_data_mem #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 19,
    parameter int LED_W  = 8,
    parameter int SW_W   = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    // scalar port A
    input  logic [ADDR_W-1:0]                 addr_a,
    input  logic [7:0]                        wdata_a,
    input  logic                              wren_a,
    input  logic                              sext_a,
    output logic [31:0]                       q_a,
    // vector port B
    input  logic [ADDR_W-$clog2(LANES)-1:0]   addr_b,
    input  logic [8*LANES-1:0]                data_b,
    input  logic                              wren_b,
    input  logic [LANES-1:0]                  be_b,
    output logic [8*LANES-1:0]                q_b,
    // board I/O
    output logic [LED_W-1:0]                  LEDs,
    input  logic [SW_W-1:0]                   Switches
);

    localparam int c_LANE_W = $clog2(LANES);
    localparam int c_ROW_W  = ADDR_W - c_LANE_W;
    localparam int c_ROWS   = 1 << c_ROW_W;

    // I/O window register offsets inside the top row
    localparam logic [c_LANE_W-1:0] c_OFS_LED = c_LANE_W'(0);
    localparam logic [c_LANE_W-1:0] c_OFS_SW  = c_LANE_W'(1);

    // ------------------------------------------------------------------------
    // Port A address decode
    // ------------------------------------------------------------------------
    logic [c_ROW_W-1:0]  w_row_a;
    logic [c_LANE_W-1:0] w_lane_a;
    logic                w_io_a;
    logic                w_we_a;
    logic                w_led_we;
    logic [LANES-1:0]    w_we_b;

    assign w_row_a  = addr_a[ADDR_W-1:c_LANE_W];
    assign w_lane_a = addr_a[c_LANE_W-1:0];
    // The top vector row is I/O for port A only; port B sees plain memory.
    assign w_io_a   = &w_row_a;
    // Writes presented while reset is high are dropped on both ports.
    assign w_we_a   = wren_a & ~w_io_a & ~reset;
    assign w_led_we = wren_a & w_io_a & (w_lane_a == c_OFS_LED);
    assign w_we_b   = be_b & {LANES{wren_b & ~reset}};

    // ------------------------------------------------------------------------
    // Byte banks
    // ------------------------------------------------------------------------
    logic [LANES-1:0][7:0] w_bank_rd_a;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
            logic [7:0] r_mem [c_ROWS];
            logic [7:0] r_rd_a;
            logic [7:0] r_rd_b;
            logic       w_we_a_here;

            assign w_we_a_here = w_we_a && (w_lane_a == c_LANE_W'(gi));

            // Array update plus port A read; read-first, and port B's write
            // is ordered last so it wins when both ports hit the same byte.
            always_ff @(posedge clk) begin
                r_rd_a <= r_mem[w_row_a];
                if (w_we_a_here) begin
                    r_mem[w_row_a] <= wdata_a;
                end
                if (w_we_b[gi]) begin
                    r_mem[addr_b] <= data_b[8*gi +: 8];
                end
            end

            // Port B read register for this lane, cleared by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_b <= 8'h00;
                end else begin
                    r_rd_b <= r_mem[addr_b];
                end
            end

            assign w_bank_rd_a[gi]     = r_rd_a;
            assign q_b[8*gi +: 8]      = r_rd_b;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Board I/O: LED register and switch synchroniser
    // ------------------------------------------------------------------------
    logic [LED_W-1:0] r_leds;
    logic [SW_W-1:0]  r_sw_meta;
    logic [SW_W-1:0]  r_sw_sync;

    // LED register loads from port A writes to the LED offset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds <= '0;
        end else if (w_led_we) begin
            r_leds <= LED_W'(wdata_a);
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= Switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign LEDs = r_leds;

    // ------------------------------------------------------------------------
    // Port A read path
    // ------------------------------------------------------------------------
    logic [31:0]         w_io_rd;
    logic [c_LANE_W-1:0] r_lane_a;
    logic                r_sext_a;
    logic                r_io_sel;
    logic [31:0]         r_io_word;
    logic [7:0]          w_byte_a;

    // Select the I/O read value for the addressed window offset.
    always_comb begin
        w_io_rd = 32'h0;
        if (w_lane_a == c_OFS_LED) begin
            w_io_rd = 32'(r_leds);
        end else if (w_lane_a == c_OFS_SW) begin
            w_io_rd = 32'(r_sw_sync);
        end
    end

    // Capture port A read context; reset selects the zero I/O word so q_a=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_a  <= '0;
            r_sext_a  <= 1'b0;
            r_io_sel  <= 1'b1;
            r_io_word <= 32'h0;
        end else begin
            r_lane_a  <= w_lane_a;
            r_sext_a  <= sext_a;
            r_io_sel  <= w_io_a;
            r_io_word <= w_io_rd;
        end
    end

    assign w_byte_a = w_bank_rd_a[r_lane_a];
    assign q_a      = r_io_sel ? r_io_word
                               : {{24{w_byte_a[7] & r_sext_a}}, w_byte_a};

endmodule
`default_nettype wire

// File: tb/tb_simd_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_data_mem
// Brief    : Self-checking bench for simd_data_mem. A byte-addressed model
//            predicts every output of the default-size instance; a small
//            LANES=4 / ADDR_W=10 instance gets hand-computed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_data_mem;

    localparam int          L       = 16;
    localparam int          AW      = 19;
    localparam int          BW      = AW - 4;
    localparam int unsigned IO_BASE = (1 << AW) - L;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic           reset;
    logic [AW-1:0]  addr_a;
    logic [7:0]     wdata_a;
    logic           wren_a;
    logic           sext_a;
    logic [31:0]    q_a;
    logic [BW-1:0]  addr_b;
    logic [8*L-1:0] data_b;
    logic           wren_b;
    logic [L-1:0]   be_b;
    logic [8*L-1:0] q_b;
    logic [7:0]     LEDs;
    logic [2:0]     Switches;

    // small instance signals
    logic [9:0]  s_addr_a;
    logic [7:0]  s_wdata_a;
    logic        s_wren_a;
    logic        s_sext_a;
    logic [31:0] s_q_a;
    logic [7:0]  s_addr_b;
    logic [31:0] s_data_b;
    logic        s_wren_b;
    logic [3:0]  s_be_b;
    logic [31:0] s_q_b;
    logic [7:0]  s_leds;
    logic [2:0]  s_sw;

    simd_data_mem dut (
        .clk(clk), .reset(reset),
        .addr_a(addr_a), .wdata_a(wdata_a), .wren_a(wren_a), .sext_a(sext_a), .q_a(q_a),
        .addr_b(addr_b), .data_b(data_b), .wren_b(wren_b), .be_b(be_b), .q_b(q_b),
        .LEDs(LEDs), .Switches(Switches)
    );

    simd_data_mem #(.LANES(4), .ADDR_W(10), .LED_W(8), .SW_W(3)) dut_small (
        .clk(clk), .reset(reset),
        .addr_a(s_addr_a), .wdata_a(s_wdata_a), .wren_a(s_wren_a), .sext_a(s_sext_a), .q_a(s_q_a),
        .addr_b(s_addr_b), .data_b(s_data_b), .wren_b(s_wren_b), .be_b(s_be_b), .q_b(s_q_b),
        .LEDs(s_leds), .Switches(s_sw)
    );

    // ------------------------------------------------------------------------
    // Counters and comparison helper
    // ------------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: plain byte map plus I/O state
    // ------------------------------------------------------------------------
    bit [7:0]       mdl [int unsigned];
    logic [7:0]     m_led = 8'h0;
    logic [2:0]     m_sw1 = 3'h0;
    logic [2:0]     m_sw2 = 3'h0;
    logic [31:0]    e_qa;
    logic [8*L-1:0] e_qb;
    logic [7:0]     e_led;
    bit             e_qa_ok;
    bit             e_qb_ok;
    bit             exp_valid = 1'b0;

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        int unsigned a;
        int unsigned base;
        logic [7:0]  b;
        a    = int'(addr_a);
        base = int'(addr_b) * L;
        if (reset) begin
            e_qa = 32'h0; e_qa_ok = 1'b1;
            e_qb = '0;    e_qb_ok = 1'b1;
            m_led = 8'h0; m_sw1 = 3'h0; m_sw2 = 3'h0;
        end else begin
            // reads see the contents before this cycle's writes
            e_qb_ok = 1'b1;
            e_qb    = '0;
            for (int i = 0; i < L; i++) begin
                if (mdl.exists(base + i)) e_qb[8*i +: 8] = mdl[base + i];
                else                      e_qb_ok = 1'b0;
            end
            if (a >= IO_BASE) begin
                e_qa_ok = 1'b1;
                case (a - IO_BASE)
                    0:       e_qa = {24'h0, m_led};
                    1:       e_qa = {29'h0, m_sw2};
                    default: e_qa = 32'h0;
                endcase
            end else if (mdl.exists(a)) begin
                e_qa_ok = 1'b1;
                b       = mdl[a];
                e_qa    = (sext_a && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
            end else begin
                e_qa_ok = 1'b0;
            end
            // writes: A first, then B so B wins on the same byte
            if (wren_a) begin
                if (a < IO_BASE)       mdl[a] = wdata_a;
                else if (a == IO_BASE) m_led  = wdata_a;
            end
            if (wren_b) begin
                for (int i = 0; i < L; i++)
                    if (be_b[i]) mdl[base + i] = data_b[8*i +: 8];
            end
            m_sw2 = m_sw1;
            m_sw1 = Switches;
        end
        e_led = m_led;
    endtask

    // Compare process: checks the main instance after every modelled edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_valid) begin
                if (e_qa_ok) chk("q_a", q_a, e_qa);
                if (e_qb_ok) chk("q_b", q_b, e_qb);
                chk("LEDs", LEDs, e_led);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change at the falling edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step();
        model_step();
        exp_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        addr_a = '0; wdata_a = 8'h0; wren_a = 1'b0; sext_a = 1'b0;
        addr_b = '0; data_b = '0;    wren_b = 1'b0; be_b   = '0;
    endtask

    task automatic s_idle();
        s_addr_a = '0; s_wdata_a = 8'h0; s_wren_a = 1'b0; s_sext_a = 1'b0;
        s_addr_b = '0; s_data_b = '0;    s_wren_b = 1'b0; s_be_b   = '0;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    logic [8*L-1:0] top_init;
    logic [7:0]     old_byte;

    initial begin
        reset = 1'b1; Switches = 3'h0; s_sw = 3'h0;
        idle(); s_idle();

        // reset state
        step(); step();
        chk("rst_q_a", q_a, 32'h0);
        chk("rst_q_b", q_b, 128'h0);
        chk("rst_leds", LEDs, 8'h0);
        reset = 1'b0;

        // fill rows 0..7 and the top row through port B
        for (int r = 0; r < 9; r++) begin
            idle();
            wren_b = 1'b1; be_b = '1;
            addr_b = (r == 8) ? '1 : BW'(r);
            data_b = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (r == 8) top_init = data_b;
            step();
        end

        // sign / zero extension
        idle(); addr_a = 19'h00010; wdata_a = 8'h85; wren_a = 1'b1; step();
        idle(); addr_a = 19'h00010; sext_a = 1'b1; addr_b = 15'd1; step();
        chk("sext_on", q_a, 32'hFFFFFF85);
        chk("b_word1_lane0", q_b[7:0], 8'h85);
        idle(); addr_a = 19'h00010; step();
        chk("sext_off", q_a, 32'h00000085);

        // byte enables
        idle(); addr_b = 15'd2; wren_b = 1'b1; be_b = 16'h00FF;
        for (int i = 0; i < L; i++) data_b[8*i +: 8] = 8'(i + 1);
        step();
        idle(); addr_b = 15'd2; addr_a = 19'h00023; step();
        chk("be_low_lanes", q_b[63:0], 64'h0807060504030201);
        chk("be_high_lanes", q_b[127:64], e_qb[127:64]);
        chk("a_read_0x23", q_a, 32'h00000004);

        // cross-port collision on byte 0x30
        idle(); old_byte = mdl[32'h30];
        addr_a = 19'h00030; wren_a = 1'b1; wdata_a = 8'h11;
        addr_b = 15'd3; wren_b = 1'b1; be_b = 16'h0001; data_b[7:0] = 8'h22;
        step();
        chk("col_old_a", q_a, {24'h0, old_byte});
        chk("col_old_b", q_b[7:0], old_byte);
        idle(); addr_a = 19'h00030; addr_b = 15'd3; step();
        chk("col_a", q_a, 32'h00000022);
        chk("col_b", q_b[7:0], 8'h22);

        // MMIO: LED write, top row untouched, switch read
        idle(); addr_a = 19'h7FFF0; wdata_a = 8'hA5; wren_a = 1'b1; step();
        chk("led_write", LEDs, 8'hA5);
        idle(); addr_a = 19'h7FFF0; sext_a = 1'b1; addr_b = '1; step();
        chk("led_read", q_a, 32'h000000A5);
        chk("top_row_kept", q_b, top_init);
        Switches = 3'b101;
        idle(); step(); step();
        addr_a = 19'h7FFF1; step();
        chk("switch_read", q_a, 32'h00000005);

        // memory survives reset; writes in reset cycles are dropped
        idle(); addr_a = 19'h0; wdata_a = 8'h3C; wren_a = 1'b1; step();
        reset = 1'b1;
        idle(); wren_b = 1'b1; be_b = '1; data_b = {16{8'h5A}};
        addr_a = 19'h7FFF0; wren_a = 1'b1; wdata_a = 8'hC3;
        step(); step();
        chk("rst2_q_a", q_a, 32'h0);
        chk("rst2_q_b", q_b, 128'h0);
        chk("rst2_leds", LEDs, 8'h0);
        reset = 1'b0;
        idle(); addr_a = 19'h0; step();
        chk("mem_persist", q_a, 32'h0000003C);

        // randomized traffic inside the initialised region
        for (int n = 0; n < 1500; n++) begin
            reset   = ($urandom_range(0, 99) == 0);
            addr_a  = ($urandom_range(0, 7) == 0) ? AW'(IO_BASE + $urandom_range(0, 15))
                                                  : AW'($urandom_range(0, 127));
            wdata_a = 8'($urandom());
            wren_a  = $urandom_range(0, 1) == 1;
            sext_a  = $urandom_range(0, 1) == 1;
            addr_b  = ($urandom_range(0, 8) == 8) ? '1 : BW'($urandom_range(0, 7));
            data_b  = {$urandom(), $urandom(), $urandom(), $urandom()};
            wren_b  = $urandom_range(0, 1) == 1;
            be_b    = 16'($urandom());
            if ($urandom_range(0, 7) == 0) Switches = 3'($urandom());
            step();
        end
        reset = 1'b0; idle();
        exp_valid = 1'b0;

        // small instance: LANES=4, ADDR_W=10, I/O window at 0x3FC
        reset = 1'b1; s_idle(); tick(); tick();
        chk("s_rst_q_a", s_q_a, 32'h0);
        chk("s_rst_q_b", s_q_b, 32'h0);
        chk("s_rst_leds", s_leds, 8'h0);
        reset = 1'b0;
        s_addr_b = 8'd2; s_wren_b = 1'b1; s_be_b = 4'hF; s_data_b = 32'h04030201; tick();
        s_data_b = 32'hAABBCCDD; s_be_b = 4'b0101; tick();
        chk("s_read_first", s_q_b, 32'h04030201);
        s_wren_b = 1'b0; s_be_b = 4'h0; tick();
        chk("s_be_merge", s_q_b, 32'h04BB02DD);
        s_addr_a = 10'h009; tick();
        chk("s_a_0x009", s_q_a, 32'h00000002);
        s_addr_a = 10'h00A; s_sext_a = 1'b1; tick();
        chk("s_a_sext", s_q_a, 32'hFFFFFFBB);
        s_sext_a = 1'b0;
        s_addr_a = 10'h3FC; s_wdata_a = 8'h3C; s_wren_a = 1'b1; tick();
        chk("s_led_old", s_q_a, 32'h0);
        chk("s_led_write", s_leds, 8'h3C);
        s_wren_a = 1'b0; s_sw = 3'b110; tick();
        chk("s_led_read", s_q_a, 32'h0000003C);
        tick();
        s_addr_a = 10'h3FD; tick();
        chk("s_switch_read", s_q_a, 32'h00000006);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
